// File: rtl/wb_out_serializer_pkg.sv
// ---------------------------------------------------------------------------
// wb_out_serializer_pkg
// Shared definitions for the writeback output serializer:
//   - ser_state_e : run-control state encoding (IDLE, RUN, DRAIN, DONE)
//   - DEF_*       : default values for the serializer parameters
// ---------------------------------------------------------------------------
package wb_out_serializer_pkg;

  localparam int DEF_DATA_W     = 25;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ADDR_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/wb_dual_push_fifo.sv
// ---------------------------------------------------------------------------
// wb_dual_push_fifo
// Small register FIFO that can accept up to two words per cycle and deliver
// one. Word A is always written before word B; push_b must only be asserted
// together with push_a (the parent compacts a lone lane-1 word onto port A).
// The parent guarantees there is room for every word it pushes and never
// pops an empty FIFO.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   clear            : synchronous flush (pointers and count to zero)
//   push_a, data_a   : first word of the cycle
//   push_b, data_b   : second word of the cycle (lands behind data_a)
//   pop              : remove the head word
//   head             : current head word (register read, no input path)
//   count            : number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_dual_push_fifo #(
  parameter int DATA_W = 25,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              push_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_b;
  logic [PTR_W-1:0]  rd_ptr;

  // Second write slot sits directly behind the first; pointer wraps naturally.
  assign wr_ptr_b = wr_ptr + PTR_W'(1);
  assign head     = mem[rd_ptr];

  // Storage is reset too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_a) mem[wr_ptr]   <= data_a;
      if (push_b) mem[wr_ptr_b] <= data_b;
      wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/wb_out_serializer.sv
// ---------------------------------------------------------------------------
// wb_out_serializer
// Buffers the two-lane convolution writeback stream and serializes it onto a
// single-word ready/valid memory-write port with sequential addresses.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : pulse in IDLE; latches base_addr, flushes FIFO,
//                           clears word_cnt and overflow
//   base_addr             : first write address
//   in0_data/in0_valid    : lane-0 result (pushed first)
//   in1_data/in1_valid    : lane-1 result
//   end_op                : end of result stream (sampled in RUN only)
//   m_data/m_addr/m_valid : write request; m_ready accepts it
//   busy                  : high in RUN or DRAIN
//   done                  : one-cycle pulse once everything is written
//   overflow              : sticky flag, some input word was dropped
//   word_cnt              : words written since start (wraps)
// ---------------------------------------------------------------------------
module wb_out_serializer
  import wb_out_serializer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              end_op,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ser_state_e        state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  slots;
  logic              pop;
  logic              clear;
  logic              take0;
  logic              take1;
  logic              push_a;
  logic              push_b;
  logic [DATA_W-1:0] word_a;
  logic              drop;

  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;
  assign clear   = (state == ST_IDLE) && start;
  assign m_addr  = base_q + word_cnt;

  // A word leaving this cycle frees its slot for an incoming word.
  assign slots = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);

  // Inputs are only accepted in RUN (including the end_op cycle). A lone
  // lane-1 word is steered onto port A so it is stored as a single word;
  // when room runs short the earlier word (lane 0) wins.
  assign take0  = (state == ST_RUN) && in0_valid;
  assign take1  = (state == ST_RUN) && in1_valid;
  assign word_a = take0 ? in0_data : in1_data;
  assign push_a = (take0 || take1) && (slots != '0);
  assign push_b = take0 && take1 && (slots >= CNT_W'(2));
  assign drop   = ((take0 || take1) && !push_a) || (take0 && take1 && !push_b);

  wb_dual_push_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .push_a (push_a),
    .data_a (word_a),
    .push_b (push_b),
    .data_b (in1_data),
    .pop    (pop),
    .head   (m_data),
    .count  (count)
  );

  // Run control with registered busy/done, plus the per-run bookkeeping
  // (latched base, written-word counter, sticky overflow).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_q   <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (clear) begin
        base_q   <= base_addr;
        word_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (pop)  word_cnt <= word_cnt + ADDR_W'(1);
        if (drop) overflow <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (end_op) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (count == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
